// File: rtl/aes256_round_controller_if.sv
// rtl/aes256_round_controller_if.sv - host, round-datapath and result signals of the AES-256 round controller
interface aes256_round_controller_if #(
  parameter int RIDX_W = 4
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [0:127]      in_block_i;
  logic [0:255]      in_key_i;
  logic              in_key_reuse_i;
  logic [0:127]      rd_state_o;
  logic [0:127]      rd_key_o;
  logic              rd_final_o;
  logic [RIDX_W-1:0] rd_round_o;
  logic [0:127]      rd_state_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [0:127]      out_block_o;
  logic              busy_o;

  modport slave (
    input  in_valid_i, in_block_i, in_key_i, in_key_reuse_i, rd_state_i, out_ready_i,
    output in_ready_o, rd_state_o, rd_key_o, rd_final_o, rd_round_o, out_valid_o, out_block_o, busy_o
  );

  modport master (
    output in_valid_i, in_block_i, in_key_i, in_key_reuse_i, rd_state_i, out_ready_i,
    input  in_ready_o, rd_state_o, rd_key_o, rd_final_o, rd_round_o, out_valid_o, out_block_o, busy_o
  );
endinterface

// File: rtl/aes256_round_controller.sv
// rtl/aes256_round_controller.sv - multicycle AES-256 block sequencer driving an external round datapath
// Also holds key_expansion: combinational AES-256 schedule, round key k at bits [128k : 128k+127].
module key_expansion (
  input  logic [0:255]        initial_key,
  output logic [0:128*15-1]   round_keys
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse is x^254 = x^2 * x^4 * ... * x^128, followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [0:128*15-1] expand(input logic [0:255] key);
    logic [0:128*15-1] rk;
    logic [31:0]       tmp;
    logic [7:0]        rcon;
    rk        = '0;
    rk[0:255] = key;
    rcon      = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = rk[32*(i-1) +: 32];
      if (i % 8 == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      rk[32*i +: 32] = rk[32*(i-8) +: 32] ^ tmp;
    end
    return rk;
  endfunction

  assign round_keys = expand(initial_key);
endmodule

module aes256_round_controller #(
  parameter int NR     = 14,
  parameter int RIDX_W = 4
) (
  input logic                       clk_i,
  input logic                       reset_n_i,
  aes256_round_controller_if.slave  bus
);
  if (NR != 14 || RIDX_W < 4) begin : g_param_check
    $error("aes256_round_controller: only NR=14 with RIDX_W>=4 is supported");
  end

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  logic [1:0]        fsm;
  logic [0:127]      state_r;
  logic [0:255]      key_r;
  logic [3:0]        round_r;
  logic [0:128*15-1] round_keys;
  logic              last_round;

  key_expansion u_key_expansion (
    .initial_key (key_r),
    .round_keys  (round_keys)
  );

  assign last_round = (round_r == 4'(NR));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fsm     <= st_idle;
      state_r <= '0;
      key_r   <= '0;
      round_r <= '0;
    end else begin
      case (fsm)
        st_idle: begin
          if (bus.in_valid_i) begin
            // Round key 0 is the first key half, so AddRoundKey needs no expansion.
            if (bus.in_key_reuse_i) begin
              state_r <= bus.in_block_i ^ key_r[0:127];
            end else begin
              key_r   <= bus.in_key_i;
              state_r <= bus.in_block_i ^ bus.in_key_i[0:127];
            end
            round_r <= 4'd1;
            fsm     <= st_run;
          end
        end
        st_run: begin
          state_r <= bus.rd_state_i;
          if (last_round) begin
            round_r <= '0;
            fsm     <= st_done;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        st_done: begin
          if (bus.out_ready_i) fsm <= st_idle;
        end
        default: fsm <= st_idle;
      endcase
    end
  end

  assign bus.in_ready_o  = (fsm == st_idle);
  assign bus.busy_o      = (fsm == st_run) || (fsm == st_done);
  assign bus.out_valid_o = (fsm == st_done);
  assign bus.out_block_o = (fsm == st_done) ? state_r : '0;
  assign bus.rd_state_o  = state_r;
  assign bus.rd_key_o    = round_keys[{round_r, 7'b0} +: 128];
  assign bus.rd_round_o  = (fsm == st_run) ? RIDX_W'(round_r) : '0;
  assign bus.rd_final_o  = (fsm == st_run) && last_round;
endmodule

// File: tb/tb_aes256_round_controller.sv
// tb/tb_aes256_round_controller.sv - directed bench for aes256_round_controller with a behavioural AES round datapath
module tb_aes256_round_controller;
  logic clk;
  logic reset_n;
  logic [0:2047] sbox_tab;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [0:255] key_c3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] blk_c3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] ct_c3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] key_sp  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] blk_sp1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [0:127] ct_sp1  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [0:127] blk_sp2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [0:127] ct_sp2  = 128'h591ccb10d410ed26dc5ba74a31362870;

  aes256_round_controller_if #(.RIDX_W(4)) bus ();

  aes256_round_controller #(.NR(14), .RIDX_W(4)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  // S-box table built by brute-force inverse search.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[8*x +: 8] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] tb_round(input logic [0:127] s, input logic [0:127] k,
                                            input logic fin, input logic [0:2047] tab);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) b[i] = tab[{s[8*i +: 8], 3'b000} +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
        t[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ k[8*i +: 8];
    return o;
  endfunction

  assign bus.rd_state_i = tb_round(bus.rd_state_o, bus.rd_key_o, bus.rd_final_o, sbox_tab);

  task automatic start_block(input logic [0:127] blk, input logic [0:255] key, input logic reuse);
    bus.in_block_i     = blk;
    bus.in_key_i       = key;
    bus.in_key_reuse_i = reuse;
    bus.in_valid_i     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_block_i = '0; bus.in_key_i = '0;
    bus.in_key_reuse_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.rd_round_o !== 4'd0) begin n_err++; $display("FAIL reset_rd_round: got %0d want 0", bus.rd_round_o); end
    n_cmp++; if (bus.rd_final_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_final: got %b want 0", bus.rd_final_o); end
    n_cmp++; if (bus.out_block_o !== 128'h0) begin n_err++; $display("FAIL reset_out_block: got %h want 0", bus.out_block_o); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_keys();
    start_block(blk_sp1, key_sp, 1'b0);
    for (int r = 1; r <= 14; r++) begin
      n_cmp++; if (bus.rd_round_o !== 4'(r)) begin n_err++; $display("FAIL rk_round: got %0d want %0d", bus.rd_round_o, r); end
      n_cmp++; if (bus.rd_final_o !== (r == 14)) begin n_err++; $display("FAIL rk_final r%0d: got %b want %b", r, bus.rd_final_o, (r == 14)); end
      if (r == 1) begin
        n_cmp++; if (bus.rd_key_o !== 128'h1f352c073b6108d72d9810a30914dff4) begin n_err++; $display("FAIL rk_key1: got %h want 1f352c073b6108d72d9810a30914dff4", bus.rd_key_o); end
      end
      if (r == 2) begin
        n_cmp++; if (bus.rd_key_o !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin n_err++; $display("FAIL rk_key2: got %h want 9ba354118e6925afa51a8b5f2067fcde", bus.rd_key_o); end
      end
      @(negedge clk);
    end
    n_cmp++; if (bus.rd_final_o !== 1'b0) begin n_err++; $display("FAIL rk_final_done: got %b want 0", bus.rd_final_o); end
    n_cmp++; if (bus.rd_round_o !== 4'd0) begin n_err++; $display("FAIL rk_round_done: got %0d want 0", bus.rd_round_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL rk_valid: got %b want 1", bus.out_valid_o); end
    n_cmp++; if (bus.out_block_o !== ct_sp1) begin n_err++; $display("FAIL rk_cipher: got %h want %h", bus.out_block_o, ct_sp1); end
    @(negedge clk);
  endtask

  task automatic test_c3_vector();
    int n;
    start_block(blk_c3, key_c3, 1'b0);
    n = 1;
    while (!bus.out_valid_o && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL c3_latency: got %0d want 15", n); end
    n_cmp++; if (bus.out_block_o !== ct_c3) begin n_err++; $display("FAIL c3_cipher: got %h want %h", bus.out_block_o, ct_c3); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL c3_busy: got %b want 1", bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL c3_valid_after: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL c3_busy_after: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_key_reuse();
    int n;
    start_block(blk_c3, {256{1'b1}}, 1'b1);
    n_cmp++; if (bus.rd_key_o !== 128'h101112131415161718191a1b1c1d1e1f) begin n_err++; $display("FAIL reuse_key1: got %h want 101112131415161718191a1b1c1d1e1f", bus.rd_key_o); end
    n = 1;
    while (!bus.out_valid_o && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (bus.out_block_o !== ct_c3) begin n_err++; $display("FAIL reuse_cipher: got %h want %h", bus.out_block_o, ct_c3); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready_i = 1'b0;
    start_block(blk_c3, key_c3, 1'b0);
    n = 1;
    while (!bus.out_valid_o && n < 40) begin
      bus.in_valid_i = n[0];
      bus.in_block_i = '1;
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL bp_latency: got %0d want 15", n); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i = i[0];
      n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b want 1", i, bus.out_valid_o); end
      n_cmp++; if (bus.out_block_o !== ct_c3) begin n_err++; $display("FAIL bp_block c%0d: got %h want %h", i, bus.out_block_o, ct_c3); end
      n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, bus.in_ready_o); end
      @(negedge clk);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.out_block_o !== 128'h0) begin n_err++; $display("FAIL bp_release_block: got %h want 0", bus.out_block_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    start_block(blk_sp1, key_sp, 1'b0);
    n = 0;
    while (bus.rd_round_o !== 4'd7 && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (bus.rd_round_o !== 4'd7) begin n_err++; $display("FAIL mid_reach_r7: got %0d want 7", bus.rd_round_o); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", bus.busy_o); end
    start_block(blk_c3, key_c3, 1'b0);
    n = 1;
    while (!bus.out_valid_o && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL mid_latency: got %0d want 15", n); end
    n_cmp++; if (bus.out_block_o !== ct_c3) begin n_err++; $display("FAIL mid_cipher: got %h want %h", bus.out_block_o, ct_c3); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int acc[$];
    logic [0:127] outs[$];
    cyc = 0;
    bus.in_key_i = key_sp; bus.in_key_reuse_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.in_block_i = blk_sp1; bus.in_valid_i = 1'b1;
    while (outs.size() < 2 && cyc < 80) begin
      if (bus.in_ready_o && bus.in_valid_i) acc.push_back(cyc);
      if (bus.out_valid_o) outs.push_back(bus.out_block_o);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      bus.in_valid_i = (acc.size() < 2);
      bus.in_block_i = (acc.size() == 0) ? blk_sp1 : blk_sp2;
    end
    bus.in_valid_i = 1'b0;
    n_cmp++; if (acc.size() !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc.size()); end
    n_cmp++; if (outs.size() !== 2) begin n_err++; $display("FAIL b2b_outputs: got %0d want 2", outs.size()); end
    n_cmp++; if (acc[1] - acc[0] !== 16) begin n_err++; $display("FAIL b2b_spacing: got %0d want 16", acc[1] - acc[0]); end
    n_cmp++; if (outs[0] !== ct_sp1) begin n_err++; $display("FAIL b2b_cipher0: got %h want %h", outs[0], ct_sp1); end
    n_cmp++; if (outs[1] !== ct_sp2) begin n_err++; $display("FAIL b2b_cipher1: got %h want %h", outs[1], ct_sp2); end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_block_i = '0; bus.in_key_i = '0;
    bus.in_key_reuse_i = 1'b0; bus.out_ready_i = 1'b1;
    build_sbox();
    test_reset();
    test_round_keys();
    test_c3_vector();
    test_key_reuse();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes256_round_controller.md
Name: aes256_round_controller

Overview:
- Multicycle sequencer for one AES-256 block encryption.
- Registers the 256-bit cipher key and feeds it to the team's combinational `key_expansion` module, which it instantiates (ports `initial_key [0:255]`, `round_keys [0:128*15-1]`; round key k occupies bits [128k : 128k+127]).
- Performs the initial AddRoundKey itself, then steps an external combinational round datapath through rounds 1..14, one round per cycle.
- Returns the ciphertext over a valid/ready handshake.

Parameters:
- NR, 14, number of rounds; only 14 is supported (elaboration error otherwise).
- RIDX_W, 4, width of the round index output.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous active-low reset.
- in_valid_i  in  1  plaintext/key offered.
- in_ready_o  out  1  controller can accept (IDLE only).
- in_block_i  in  [0:127]  plaintext, byte 0 at bits [0:7].
- in_key_i  in  [0:255]  cipher key.
- in_key_reuse_i  in  1  on accept: 1 = keep the registered key and ignore in_key_i.
- rd_state_o  out  [0:127]  state sent to the round datapath.
- rd_key_o  out  [0:127]  round key for the current round.
- rd_final_o  out  1  current round is the last one (the datapath skips MixColumns).
- rd_round_o  out  RIDX_W  current round index, 1..14; 0 when not running.
- rd_state_i  in  [0:127]  round datapath result, same cycle (combinational).
- out_valid_o  out  1  ciphertext available.
- out_ready_i  in  1  consumer accepts the ciphertext.
- out_block_o  out  [0:127]  ciphertext.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- Registers: fsm ∈ {IDLE, RUN, DONE}, state_r[0:127], key_r[0:255], round_r[3:0].
- key_expansion input is key_r; its output is combinational.
- Reset (reset_n_i=0 at an edge), regardless of the current state:
  - fsm=IDLE, state_r=0, key_r=0, round_r=0.
  - Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, rd_round_o=0, rd_final_o=0, out_block_o=0.
  - An encryption in flight is abandoned; no partial result is ever presented.
- IDLE:
  - in_ready_o=1; rd_* outputs are don't-care except rd_round_o=0 and rd_final_o=0.
  - Accept when in_valid_i=1 at an edge.
  - If in_key_reuse_i=0: key_r<=in_key_i, and state_r<=in_block_i ^ in_key_i[0:127].
  - If in_key_reuse_i=1: key_r is held, and state_r<=in_block_i ^ key_r[0:127].
  - Round key 0 equals key bits [0:127], so no expansion is needed for this step.
  - round_r<=1, fsm<=RUN.
- RUN:
  - in_ready_o=0; in_valid_i is ignored and does not stall.
  - rd_state_o=state_r, rd_key_o=round_keys[128*round_r +: 128], rd_round_o=round_r, rd_final_o=(round_r==NR).
  - Every edge: state_r<=rd_state_i.
  - If round_r==NR: fsm<=DONE and round_r<=0; otherwise round_r<=round_r+1.
  - The round counter never wraps beyond NR.
- DONE:
  - out_valid_o=1, out_block_o=state_r; state_r is held stable while out_ready_i=0.
  - Edge with out_ready_i=1: fsm<=IDLE.
  - in_ready_o stays 0 during DONE, so a new accept is possible at the earliest one cycle after the output handshake. There is no accept/complete overlap.
- Latency:
  - Accept edge at cycle T → RUN during cycles T+1..T+14 → out_valid_o first high in cycle T+15.
  - Throughput: one block per 16 cycles when out_ready_i is tied high.
- key_r changes only on a non-reuse accept, so round keys are stable throughout RUN and DONE.
- out_block_o is 0 whenever out_valid_o=0.

Test Plan:
- Round keys only. Load key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 and sample rd_key_o on successive RUN cycles:
  - round 1 → 1f352c073b6108d72d9810a30914dff4
  - round 2 → 9ba354118e6925afa51a8b5f2067fcde
  - rd_final_o is high only at rd_round_o=14.
- FIPS-197 C.3 vector, with the team's round datapath attached:
  - key 000102…1f, block 00112233445566778899aabbccddeeff → out_block_o=8ea2b7ca516745bfeafc49904b496089.
  - out_valid_o rises exactly 15 cycles after the accept edge.
- Key reuse. After the C.3 run, accept block 00112233445566778899aabbccddeeff with in_key_reuse_i=1 and in_key_i=all ones → same ciphertext 8ea2b7ca…6089, and key_r is unchanged.
- Backpressure:
  - Hold out_ready_i=0 for 10 cycles in DONE → out_valid_o and out_block_o stay stable, in_ready_o=0.
  - in_valid_i pulses during RUN and DONE are not accepted.
  - Releasing out_ready_i → IDLE next cycle.
- Reset mid-operation. Assert reset_n_i=0 at round 7 → next cycle fsm=IDLE, in_ready_o=1, out_valid_o=0. A new encryption then completes with correct ciphertext and no stale output.
- Back-to-back. Two blocks with in_valid_i and out_ready_i held high → accepts 16 cycles apart, both ciphertexts correct.
